param_double_buffer: RTL
========================

PARAM_DOUBLE_BUFFER -- requirements
Module: param_double_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter DEPTH, default 64, words per bank (power of two, 2..4096); AW = log2(DEPTH).
REQ-003 SHALL have parameter DIMS, default 3, read address-generator dimensions (1..6).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clk_en  input  1  global enable; when low, no state changes except reset.
REQ-007 SHALL have port flush  input  1  synchronous clear, qualified by clk_en.
REQ-008 SHALL have ports data_in input DATA_W, wen_in input 1: write word and write strobe.
REQ-009 SHALL have ports ren_in input 1, data_out output DATA_W, valid_out output 1: read strobe, read data, read data valid.
REQ-010 SHALL have config inputs depth 16 (words per fill), iter_cnt 16 (reads per bank), starting_addr 16, stride DIMS*16 (packed, dim 0 in LSBs), range DIMS*16 (packed), almost_count 4; all static while reset is deasserted.
REQ-011 SHALL have outputs full 1, empty 1, almost_full 1, bank_sel 1 (current write bank).

Function
REQ-012 SHALL hold two banks of DEPTH x DATA_W; write bank = bank_sel, read bank = !bank_sel.
REQ-013 SHALL use effective depth D = depth when 1 <= depth <= DEPTH, else DEPTH.
REQ-014 SHALL accept a write when clk_en && wen_in && wcnt < D: store data_in at write-bank address wcnt, increment wcnt.
REQ-015 SHALL silently drop writes when wcnt == D (full); memory and counters unchanged.
REQ-016 SHALL keep flag rbank_valid, low until the first bank switch.
REQ-017 SHALL accept a read when clk_en && ren_in && rbank_valid && rcnt < iter_cnt; rcnt increments; reads otherwise ignored.
REQ-018 SHALL present data_out with valid_out high exactly one clk_en cycle after an accepted read; valid_out low in every cycle without an accepted read on the previous edge.
REQ-019 SHALL generate read address addr = (starting_addr + sum over d of idx[d]*stride[d]) mod DEPTH, computed at >= 32 bits, truncated to AW.
REQ-020 SHALL step idx[0] per accepted read; idx[d] wraps to 0 at range[d]-1 and carries into idx[d+1]; range[d] == 0 treated as 1.
REQ-021 SHALL wrap all idx to 0 after the outermost dimension completes, continuing while rcnt < iter_cnt.
REQ-022 SHALL switch banks on an edge with clk_en high when wcnt == D and (!rbank_valid || rcnt == iter_cnt), counters evaluated before that edge.
REQ-023 SHALL on switch: toggle bank_sel, set wcnt = 0, rcnt = 0, all idx = 0, rbank_valid = 1; any read/write strobe on the switch edge is ignored.
REQ-024 SHALL treat iter_cnt == 0 as read bank immediately exhausted.
REQ-025 SHALL drive full = (wcnt == D); empty = !rbank_valid || (rcnt == iter_cnt); almost_full = (wcnt + almost_count >= D); all combinational from registered state.
REQ-026 SHALL on flush (with clk_en): clear wcnt, rcnt, idx, bank_sel, rbank_valid, valid_out; memory contents retained; flush overrides a coincident switch, read or write.
REQ-027 SHALL let a read accepted on the edge that makes rcnt == iter_cnt return valid data from the old read bank even if a switch occurs on the next edge.

Reset
REQ-028 SHALL on reset low, immediately set wcnt = 0, rcnt = 0, idx = 0, bank_sel = 0, rbank_valid = 0, valid_out = 0, data_out = 0; thus full = 0, empty = 1.
REQ-029 SHALL discard in-flight reads when reset asserts mid-operation; first cycle after release behaves as post-reset idle.
REQ-030 SHALL not initialise memory contents on reset.

Verification
REQ-031 SHALL cover: depth=4, iter_cnt=4, stride=(1,0,0), range=(4,1,1); write 10,11,12,13 -> bank_sel 0->1 one edge after 4th write; reads return 10,11,12,13, each valid_out one cycle after ren_in.
REQ-032 SHALL cover: depth=27, stride=(1,3,9), range=(3,3,3), iter_cnt=27, data = address -> reads return 0..26 in order; iter_cnt=30 -> reads 27..29 return 0,1,2 (wrap).
REQ-033 SHALL cover: fill bank 1 while bank 0 has 2 of 4 reads left -> no switch, full=1, 5th write dropped; switch one edge after final read; dropped word never appears.
REQ-034 SHALL cover: last write and last read accepted on the same edge -> switch on the next edge; final read data valid from old bank.
REQ-035 SHALL cover: flush asserted mid-read with clk_en=1 -> next cycle valid_out=0, empty=1, bank_sel=0; with clk_en=0 flush has no effect.
REQ-036 SHALL cover: reset pulsed low between clock edges during reads -> outputs take REQ-028 values without a clock edge.

Source files
------------

// File: rtl/param_double_buffer_if.sv
// -----------------------------------------------------------------------------
// param_double_buffer_if
// Purpose : groups the streaming write/read handshake and the status flags of
//           the ping-pong parameter buffer.
// Signals : data_in/wen_in   - write word and write strobe (producer side)
//           ren_in           - read strobe (consumer side)
//           data_out/valid_out - read data and its one-cycle-late qualifier
//           full/empty/almost_full/bank_sel - buffer status
// Modports: master drives the strobes and data_in, slave (the buffer) drives
//           read data and status.
// -----------------------------------------------------------------------------
interface param_double_buffer_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] data_in;
  logic              wen_in;
  logic              ren_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              bank_sel;

  modport master (
    output data_in, wen_in, ren_in,
    input  data_out, valid_out, full, empty, almost_full, bank_sel
  );

  modport slave (
    input  data_in, wen_in, ren_in,
    output data_out, valid_out, full, empty, almost_full, bank_sel
  );
endinterface

// File: rtl/param_double_buffer.sv
// -----------------------------------------------------------------------------
// param_double_buffer
// Purpose : two-bank ping-pong buffer. One bank is filled linearly while the
//           other is read through a multi-dimensional strided address
//           generator. Banks swap once the write bank holds 'depth' words and
//           the read bank has delivered 'iter_cnt' words (or was never valid).
// Ports   : clk          - sole clock, rising edge
//           reset        - asynchronous active-low reset
//           clk_en       - global enable, freezes all state when low
//           flush        - synchronous clear (qualified by clk_en)
//           bus          - handshake/data/status interface (slave side)
//           depth        - words per fill (0 or > DEPTH means DEPTH)
//           iter_cnt     - reads per bank
//           starting_addr- base read address
//           stride/range - per-dimension stride and range, dim 0 in LSBs
//           almost_count - almost_full look-ahead
// -----------------------------------------------------------------------------
module param_double_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int DIMS   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 flush,
  param_double_buffer_if.slave bus,
  input  logic [15:0]          depth,
  input  logic [15:0]          iter_cnt,
  input  logic [15:0]          starting_addr,
  input  logic [DIMS*16-1:0]   stride,
  input  logic [DIMS*16-1:0]   range,
  input  logic [3:0]           almost_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] W_ONE = {{AW{1'b0}}, 1'b1};

  // Both banks in one array; the bank select is the address MSB.
  logic [DATA_W-1:0] mem_r [2*DEPTH];

  logic [AW:0]       wcnt_r;
  logic [15:0]       rcnt_r;
  logic [15:0]       idx_r [DIMS];
  logic              bank_sel_r;
  logic              rbank_valid_r;
  logic              valid_out_r;
  logic [DATA_W-1:0] data_out_r;

  logic [AW:0]       eff_depth_s;
  logic [15:0]       lim_s [DIMS];
  logic [15:0]       idx_nxt_s [DIMS];
  logic              carry_s;
  logic [31:0]       addr_sum_s;
  logic [AW-1:0]     raddr_s;
  logic              full_s;
  logic              rd_done_s;
  logic              switch_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              unused_ok_s;

  // Effective fill depth: out-of-range requests fall back to the full bank.
  always_comb begin
    if ((depth != 16'd0) && (int'(depth) <= DEPTH)) begin
      eff_depth_s = depth[AW:0];
    end else begin
      eff_depth_s = (AW+1)'(DEPTH);
    end
  end

  // Last index value per dimension; a zero range behaves like a range of one.
  always_comb begin
    for (int d = 0; d < DIMS; d++) begin
      if (range[d*16 +: 16] == 16'd0) begin
        lim_s[d] = 16'd0;
      end else begin
        lim_s[d] = range[d*16 +: 16] - 16'd1;
      end
    end
  end

  // Odometer step: dim 0 advances, wrapping dims carry outward; a carry out
  // of the outermost dim leaves every index at zero.
  always_comb begin
    carry_s = 1'b1;
    for (int d = 0; d < DIMS; d++) begin
      if (carry_s) begin
        if (idx_r[d] >= lim_s[d]) begin
          idx_nxt_s[d] = 16'd0;
          carry_s      = 1'b1;
        end else begin
          idx_nxt_s[d] = idx_r[d] + 16'd1;
          carry_s      = 1'b0;
        end
      end else begin
        idx_nxt_s[d] = idx_r[d];
      end
    end
  end

  // Read address; only the low AW bits matter because DEPTH is a power of two.
  always_comb begin
    addr_sum_s = 32'(starting_addr);
    for (int d = 0; d < DIMS; d++) begin
      addr_sum_s = addr_sum_s + (32'(idx_r[d]) * 32'(stride[d*16 +: 16]));
    end
  end

  assign raddr_s     = addr_sum_s[AW-1:0];
  assign unused_ok_s = ^{addr_sum_s[31:AW], depth[15:AW+1]};

  assign full_s    = (wcnt_r == eff_depth_s);
  assign rd_done_s = !rbank_valid_r || (rcnt_r == iter_cnt);
  assign switch_s  = full_s && rd_done_s;
  // Flush and bank switch both swallow any strobe on that edge.
  assign wr_acc_s  = clk_en && !flush && !switch_s && bus.wen_in && (wcnt_r < eff_depth_s);
  assign rd_acc_s  = clk_en && !flush && !switch_s && bus.ren_in && rbank_valid_r &&
                     (rcnt_r < iter_cnt);

  // Bank storage: no reset so contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[{bank_sel_r, wcnt_r[AW-1:0]}] <= bus.data_in;
    end
  end

  // Counters, address indices, bank control and the registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt_r        <= '0;
      rcnt_r        <= 16'd0;
      bank_sel_r    <= 1'b0;
      rbank_valid_r <= 1'b0;
      valid_out_r   <= 1'b0;
      data_out_r    <= '0;
      for (int d = 0; d < DIMS; d++) begin
        idx_r[d] <= 16'd0;
      end
    end else if (clk_en) begin
      if (flush) begin
        wcnt_r        <= '0;
        rcnt_r        <= 16'd0;
        bank_sel_r    <= 1'b0;
        rbank_valid_r <= 1'b0;
        valid_out_r   <= 1'b0;
        for (int d = 0; d < DIMS; d++) begin
          idx_r[d] <= 16'd0;
        end
      end else if (switch_s) begin
        wcnt_r        <= '0;
        rcnt_r        <= 16'd0;
        bank_sel_r    <= ~bank_sel_r;
        rbank_valid_r <= 1'b1;
        valid_out_r   <= 1'b0;
        for (int d = 0; d < DIMS; d++) begin
          idx_r[d] <= 16'd0;
        end
      end else begin
        valid_out_r <= rd_acc_s;
        if (wr_acc_s) begin
          wcnt_r <= wcnt_r + W_ONE;
        end
        if (rd_acc_s) begin
          rcnt_r     <= rcnt_r + 16'd1;
          data_out_r <= mem_r[{~bank_sel_r, raddr_s}];
          for (int d = 0; d < DIMS; d++) begin
            idx_r[d] <= idx_nxt_s[d];
          end
        end
      end
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.valid_out   = valid_out_r;
  assign bus.bank_sel    = bank_sel_r;
  assign bus.full        = full_s;
  assign bus.empty       = rd_done_s;
  assign bus.almost_full = (32'(wcnt_r) + 32'(almost_count)) >= 32'(eff_depth_s);
endmodule
